// File: rtl/video_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_pattern_gen
// Purpose  : Parametrised raster timing generator (DE/HSYNC/VSYNC) with five
//            runtime-selectable 24-bit RGB test patterns, pixel coordinates,
//            a frame-start strobe and a free-running frame counter.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module video_pattern_gen #(
  parameter int HSYNC      = 40,
  parameter int HBACK      = 220,
  parameter int HACTIVE    = 1280,
  parameter int HFRONT     = 110,
  parameter int VSYNC      = 5,
  parameter int VBACK      = 20,
  parameter int VACTIVE    = 720,
  parameter int VFRONT     = 5,
  parameter int HSYNC_POL  = 1,
  parameter int VSYNC_POL  = 1,
  parameter int NUM_BARS   = 7,
  parameter int GRID_PITCH = 32,
  parameter int BOX_SIZE   = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [2:0]                 mode_in,
  input  logic                       mode_valid,
  input  logic [23:0]                solid_color,
  output logic [23:0]                video_data,
  output logic                       video_de,
  output logic                       video_hsync,
  output logic                       video_vsync,
  output logic [$clog2(HACTIVE)-1:0] pixel_x,
  output logic [$clog2(VACTIVE)-1:0] pixel_y,
  output logic                       frame_start,
  output logic [15:0]                frame_count
);

  // --------------------------------------------------------------------------
  // Raster geometry
  // --------------------------------------------------------------------------
  localparam int HTOTAL = HSYNC + HBACK + HACTIVE + HFRONT;
  localparam int VTOTAL = VSYNC + VBACK + VACTIVE + VFRONT;
  localparam int HCW    = $clog2(HTOTAL);
  localparam int VCW    = $clog2(VTOTAL);
  localparam int XW     = $clog2(HACTIVE);
  localparam int YW     = $clog2(VACTIVE);

  // All counter comparisons are done on 32-bit zero-extended copies so the
  // constants never need to be squeezed into the narrow counter widths.
  localparam logic [31:0] H_SYNC_END = HSYNC;
  localparam logic [31:0] H_ACT_BEG  = HSYNC + HBACK;
  localparam logic [31:0] H_ACT_END  = HSYNC + HBACK + HACTIVE;
  localparam logic [31:0] H_LAST     = HTOTAL - 1;
  localparam logic [31:0] V_SYNC_END = VSYNC;
  localparam logic [31:0] V_ACT_BEG  = VSYNC + VBACK;
  localparam logic [31:0] V_ACT_END  = VSYNC + VBACK + VACTIVE;
  localparam logic [31:0] V_LAST     = VTOTAL - 1;

  // Pattern constants
  localparam logic [31:0] NB       = NUM_BARS;
  localparam logic [31:0] HA       = HACTIVE;
  localparam logic [31:0] VA       = VACTIVE;
  localparam logic [31:0] GP_MASK  = GRID_PITCH - 1;
  localparam logic [31:0] BOX      = BOX_SIZE;
  localparam logic [31:0] BX_MAX   = HACTIVE - BOX_SIZE;
  localparam logic [31:0] BY_MAX   = VACTIVE - BOX_SIZE;

  localparam logic HPOL = (HSYNC_POL != 0);
  localparam logic VPOL = (VSYNC_POL != 0);

  // Pattern selector encoding
  localparam logic [2:0] MODE_BARS  = 3'd0;
  localparam logic [2:0] MODE_GRID  = 3'd1;
  localparam logic [2:0] MODE_GRAD  = 3'd2;
  localparam logic [2:0] MODE_SOLID = 3'd3;
  localparam logic [2:0] MODE_BOX   = 3'd4;

  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] NAVY  = 24'h000080;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;
  logic [2:0]     pending_mode;
  logic [2:0]     active_mode;
  logic [23:0]    solid_reg;
  logic [XW-1:0]  box_x;
  logic [YW-1:0]  box_y;
  logic           box_x_neg;
  logic           box_y_neg;

  // --------------------------------------------------------------------------
  // Combinational decode of the current counter state
  // --------------------------------------------------------------------------
  logic [31:0]    h_u;
  logic [31:0]    v_u;
  logic           origin;
  logic           hsync_act;
  logic           vsync_act;
  logic           de_c;
  logic [31:0]    x_full;
  logic [31:0]    y_full;
  logic [XW-1:0]  x_c;
  logic [YW-1:0]  y_c;

  // Timing decode: sync windows, active window and active-area coordinates.
  always_comb begin
    h_u       = 32'(h_cnt);
    v_u       = 32'(v_cnt);
    origin    = (h_u == 32'd0) && (v_u == 32'd0);
    hsync_act = (h_u < H_SYNC_END);
    vsync_act = (v_u < V_SYNC_END);
    de_c      = (h_u >= H_ACT_BEG) && (h_u < H_ACT_END) &&
                (v_u >= V_ACT_BEG) && (v_u < V_ACT_END);
    x_full    = h_u - H_ACT_BEG;
    y_full    = v_u - V_ACT_BEG;
    x_c       = de_c ? XW'(x_full) : '0;
    y_c       = de_c ? YW'(y_full) : '0;
  end

  // --------------------------------------------------------------------------
  // Pattern generation for the current pixel
  // --------------------------------------------------------------------------
  logic [31:0] x_u;
  logic [31:0] y_u;
  logic [31:0] bx_u;
  logic [31:0] by_u;
  logic [2:0]  bar_idx;
  logic [23:0] bar_color;
  logic [7:0]  grad;
  logic        grid_on;
  logic        box_on;
  logic [23:0] pattern;

  // Per-pattern terms; the bar index uses a full 32-bit product before the
  // divide so narrow x widths never overflow the scaling.
  always_comb begin
    x_u     = 32'(x_c);
    y_u     = 32'(y_c);
    bx_u    = 32'(box_x);
    by_u    = 32'(box_y);
    bar_idx = 3'((x_u * NB) / HA);
    grad    = 8'((x_u * 32'd256) / HA);
    grid_on = ((x_u & GP_MASK) == 32'd0) || ((y_u & GP_MASK) == 32'd0) ||
              (x_u == HA - 32'd1) || (y_u == VA - 32'd1);
    box_on  = (x_u >= bx_u) && (x_u < bx_u + BOX) &&
              (y_u >= by_u) && (y_u < by_u + BOX);
  end

  // Colour-bar lookup table, indexed modulo 8.
  always_comb begin
    bar_color = BLACK;
    case (bar_idx)
      3'd0:    bar_color = 24'hFFFFFF;
      3'd1:    bar_color = 24'hFFFF00;
      3'd2:    bar_color = 24'h00FFFF;
      3'd3:    bar_color = 24'h00FF00;
      3'd4:    bar_color = 24'hFF00FF;
      3'd5:    bar_color = 24'hFF0000;
      3'd6:    bar_color = 24'h0000FF;
      default: bar_color = 24'h000000;
    endcase
  end

  // Pattern mux driven by the frame-stable active mode.
  always_comb begin
    pattern = BLACK;
    case (active_mode)
      MODE_BARS:  pattern = bar_color;
      MODE_GRID:  pattern = grid_on ? WHITE : BLACK;
      MODE_GRAD:  pattern = {grad, grad, grad};
      MODE_SOLID: pattern = solid_reg;
      MODE_BOX:   pattern = box_on ? GREEN : NAVY;
      default:    pattern = BLACK;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // Horizontal/vertical raster counters; vertical advances on horizontal wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_u == H_LAST) begin
      h_cnt <= '0;
      if (v_u == V_LAST) begin
        v_cnt <= '0;
      end else begin
        v_cnt <= v_cnt + 1'b1;
      end
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Mode request capture; the pending value only becomes active at the origin
  // so a frame is never split between two patterns.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_mode <= MODE_BARS;
      active_mode  <= MODE_BARS;
      solid_reg    <= '0;
    end else begin
      if (mode_valid) begin
        pending_mode <= mode_in;
      end
      if (origin) begin
        // A request arriving on the origin cycle applies immediately.
        active_mode <= mode_valid ? mode_in : pending_mode;
        solid_reg   <= solid_color;
      end
    end
  end

  // Bouncing-box position, stepped once per frame on each axis independently.
  always_ff @(posedge clock) begin
    if (reset) begin
      box_x     <= '0;
      box_y     <= '0;
      box_x_neg <= 1'b0;
      box_y_neg <= 1'b0;
    end else if (origin) begin
      if (!box_x_neg) begin
        if (bx_u == BX_MAX) begin
          box_x_neg <= 1'b1;
          box_x     <= box_x - 1'b1;
        end else begin
          box_x     <= box_x + 1'b1;
        end
      end else begin
        if (bx_u == 32'd0) begin
          box_x_neg <= 1'b0;
          box_x     <= box_x + 1'b1;
        end else begin
          box_x     <= box_x - 1'b1;
        end
      end
      if (!box_y_neg) begin
        if (by_u == BY_MAX) begin
          box_y_neg <= 1'b1;
          box_y     <= box_y - 1'b1;
        end else begin
          box_y     <= box_y + 1'b1;
        end
      end else begin
        if (by_u == 32'd0) begin
          box_y_neg <= 1'b0;
          box_y     <= box_y + 1'b1;
        end else begin
          box_y     <= box_y - 1'b1;
        end
      end
    end
  end

  // Registered video outputs, one clock behind the counter state.
  always_ff @(posedge clock) begin
    if (reset) begin
      video_de    <= 1'b0;
      video_data  <= '0;
      video_hsync <= ~HPOL;
      video_vsync <= ~VPOL;
      pixel_x     <= '0;
      pixel_y     <= '0;
    end else begin
      video_de    <= de_c;
      video_data  <= de_c ? pattern : BLACK;
      video_hsync <= ~(hsync_act ^ HPOL);
      video_vsync <= ~(vsync_act ^ VPOL);
      pixel_x     <= x_c;
      pixel_y     <= y_c;
    end
  end

  // Frame strobe and wrapping frame counter, both triggered by the origin.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_start <= origin;
      if (origin) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_pattern_gen
// Purpose  : Directed bench for video_pattern_gen on a 22x11 raster. Expected
//            pixels are queued ahead of each frame and consumed by a monitor.
// Revision : 1.0
// ============================================================================
module tb_video_pattern_gen;

  logic        clock;
  logic        reset;
  logic        rst2;
  logic [2:0]  mode_in;
  logic        mode_valid;
  logic [23:0] solid_color;

  logic [23:0] video_data;
  logic        video_de;
  logic        video_hsync;
  logic        video_vsync;
  logic [3:0]  pixel_x;
  logic [2:0]  pixel_y;
  logic        frame_start;
  logic [15:0] frame_count;

  logic [23:0] data2;
  logic        de2;
  logic        hs2;
  logic        vs2;
  logic [3:0]  x2;
  logic [2:0]  y2;
  logic        fs2;
  logic [15:0] fc2;

  video_pattern_gen #(
    .HSYNC(2), .HBACK(2), .HACTIVE(16), .HFRONT(2),
    .VSYNC(1), .VBACK(1), .VACTIVE(8), .VFRONT(1),
    .HSYNC_POL(1), .VSYNC_POL(1),
    .NUM_BARS(8), .GRID_PITCH(4), .BOX_SIZE(4)
  ) dut (
    .clock(clock), .reset(reset), .mode_in(mode_in), .mode_valid(mode_valid),
    .solid_color(solid_color), .video_data(video_data), .video_de(video_de),
    .video_hsync(video_hsync), .video_vsync(video_vsync), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .frame_start(frame_start), .frame_count(frame_count)
  );

  // Second instance with active-low hsync for the mid-frame reset scenario.
  video_pattern_gen #(
    .HSYNC(2), .HBACK(2), .HACTIVE(16), .HFRONT(2),
    .VSYNC(1), .VBACK(1), .VACTIVE(8), .VFRONT(1),
    .HSYNC_POL(0), .VSYNC_POL(1),
    .NUM_BARS(8), .GRID_PITCH(4), .BOX_SIZE(4)
  ) dut2 (
    .clock(clock), .reset(rst2), .mode_in(mode_in), .mode_valid(mode_valid),
    .solid_color(solid_color), .video_data(data2), .video_de(de2),
    .video_hsync(hs2), .video_vsync(vs2), .pixel_x(x2),
    .pixel_y(y2), .frame_start(fs2), .frame_count(fc2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          frame;
    int          x;
    int          y;
    logic [23:0] rgb;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   frames_seen = 0;
  int   blank_bad   = 0;

  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] NAVY  = 24'h000080;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_px(input int f, input int x, input int y, input logic [23:0] c);
    exp_t e;
    e.frame = f; e.x = x; e.y = y; e.rgb = c;
    q.push_back(e);
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    @(negedge clock);
    while (!frame_start && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!frame_start) check("frame_timeout", 32'(n), 32'd242);
  endtask

  task automatic wait_row(input int y);
    int n;
    n = 0;
    while (!(video_de && pixel_y == 3'(y)) && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!(video_de && pixel_y == 3'(y))) check("row_timeout", 32'(n), 32'd0);
  endtask

  task automatic set_mode(input logic [2:0] m);
    mode_in    = m;
    mode_valid = 1'b1;
    @(negedge clock);
    mode_valid = 1'b0;
  endtask

  // Box expectations for frame k: position after k origin steps.
  task automatic push_box(input int k);
    int m, bx, by;
    m  = k % 24;
    bx = (m <= 12) ? m : 24 - m;
    m  = k % 8;
    by = (m <= 4) ? m : 8 - m;
    if (bx > 0) push_px(k, bx - 1, by, NAVY);
    push_px(k, bx, by, GREEN);
    if (bx + 4 < 16) push_px(k, bx + 4, by, NAVY);
    push_px(k, bx + 3, by + 3, GREEN);
    if (by + 4 < 8) push_px(k, bx, by + 4, NAVY);
  endtask

  // Monitor: counts frames, checks blanking, pops expected pixels as they pass.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) continue;
      if (frame_start) frames_seen++;
      if (!video_de && (video_data != 24'd0 || pixel_x != 4'd0 || pixel_y != 3'd0))
        blank_bad++;
      while (q.size() > 0 && q[0].frame < frames_seen) begin
        vectors++;
        miscompares++;
        $display("FAIL pixel f%0d (%0d,%0d): never presented, expected %06h",
                 q[0].frame, q[0].x, q[0].y, q[0].rgb);
        void'(q.pop_front());
      end
      if (video_de && q.size() > 0 && q[0].frame == frames_seen &&
          int'(pixel_x) == q[0].x && int'(pixel_y) == q[0].y) begin
        vectors++;
        if (video_data !== q[0].rgb) begin
          miscompares++;
          $display("FAIL pixel f%0d (%0d,%0d): got %06h expected %06h",
                   q[0].frame, q[0].x, q[0].y, video_data, q[0].rgb);
        end
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] bars [8];
    int cyc, de_n, hs_n, vs_n;
    bit mv_done;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    reset = 1'b1; rst2 = 1'b1;
    mode_in = 3'd0; mode_valid = 1'b0; solid_color = 24'd0;
    repeat (3) @(negedge clock);

    check("rst_de",    32'(video_de),    32'd0);
    check("rst_data",  32'(video_data),  32'd0);
    check("rst_hsync", 32'(video_hsync), 32'd0);
    check("rst_vsync", 32'(video_vsync), 32'd0);
    check("rst_x",     32'(pixel_x),     32'd0);
    check("rst_y",     32'(pixel_y),     32'd0);
    check("rst_fs",    32'(frame_start), 32'd0);
    check("rst_fc",    32'(frame_count), 32'd0);
    check("rst_hs2",   32'(hs2),         32'd1);

    // Frame 1: colour bars, index = x/2.
    push_px(1, 0, 0, 24'hFFFFFF);
    push_px(1, 1, 0, 24'hFFFFFF);
    push_px(1, 2, 0, 24'hFFFF00);
    push_px(1, 8, 0, 24'hFF00FF);
    push_px(1, 15, 0, 24'h000000);
    push_px(1, 6, 4, 24'h00FF00);
    for (int x = 0; x < 16; x++) push_px(1, x, 7, bars[x / 2]);

    reset = 1'b0; rst2 = 1'b0;
    @(negedge clock);
    check("first_fs", 32'(frame_start), 32'd1);
    check("first_fc", 32'(frame_count), 32'd1);

    // Measure one whole frame; request solid mode mid-frame at y=3.
    cyc = 0; de_n = 0; hs_n = 0; vs_n = 0; mv_done = 0;
    do begin
      de_n += int'(video_de);
      hs_n += int'(video_hsync);
      vs_n += int'(video_vsync);
      if (!mv_done && video_de && pixel_y == 3'd3) begin
        mode_in = 3'd3; mode_valid = 1'b1; solid_color = 24'h123456; mv_done = 1;
        for (int y = 0; y < 8; y++)
          for (int x = 0; x < 16; x++) push_px(2, x, y, 24'h123456);
      end else begin
        mode_valid = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end while (!frame_start && cyc < 300);
    check("frame_period", 32'(cyc),  32'd242);
    check("de_per_frame", 32'(de_n), 32'd128);
    check("hsync_clocks", 32'(hs_n), 32'd22);
    check("vsync_clocks", 32'(vs_n), 32'd22);
    check("fc_2",         32'(frame_count), 32'd2);

    // Frame 2: change solid_color mid-frame; only frame 3 may show it.
    wait_row(2);
    solid_color = 24'hABCDEF;
    push_px(3, 0, 0, 24'hABCDEF);
    push_px(3, 7, 3, 24'hABCDEF);
    push_px(3, 15, 7, 24'hABCDEF);
    wait_frame();
    check("fc_3", 32'(frame_count), 32'd3);

    // Frame 4: grid.
    wait_row(1);
    set_mode(3'd1);
    for (int x = 0; x < 16; x++) push_px(4, x, 0, 24'hFFFFFF);
    push_px(4, 0, 1, 24'hFFFFFF);
    push_px(4, 4, 1, 24'hFFFFFF);
    push_px(4, 5, 1, 24'h000000);
    push_px(4, 8, 1, 24'hFFFFFF);
    push_px(4, 12, 1, 24'hFFFFFF);
    push_px(4, 15, 1, 24'hFFFFFF);
    for (int x = 0; x < 16; x++) push_px(4, x, 4, 24'hFFFFFF);
    for (int x = 0; x < 16; x++) push_px(4, x, 7, 24'hFFFFFF);
    wait_frame();

    // Frame 5: gradient, g = 16*x.
    wait_row(1);
    set_mode(3'd2);
    push_px(5, 0, 0, 24'h000000);
    push_px(5, 1, 0, 24'h101010);
    push_px(5, 8, 0, 24'h808080);
    push_px(5, 15, 0, 24'hF0F0F0);
    push_px(5, 8, 6, 24'h808080);
    wait_frame();

    // Frames 6..24: bouncing box.
    wait_row(1);
    set_mode(3'd4);
    push_box(6);
    for (int k = 6; k < 24; k++) begin
      wait_frame();
      push_box(k + 1);
    end
    wait_frame();
    wait_frame();

    // Mid-frame reset on the active-low-hsync instance.
    begin
      int n;
      n = 0;
      while (!(de2 && y2 == 3'd5) && n < 600) begin
        @(negedge clock);
        n++;
      end
      check("dut2_row5_found", 32'(de2 && y2 == 3'd5), 32'd1);
    end
    rst2 = 1'b1;
    @(negedge clock);
    check("mid_rst_de",    32'(de2),   32'd0);
    check("mid_rst_data",  32'(data2), 32'd0);
    check("mid_rst_hsync", 32'(hs2),   32'd1);
    check("mid_rst_fc",    32'(fc2),   32'd0);
    check("mid_rst_fs",    32'(fs2),   32'd0);
    rst2 = 1'b0;
    @(negedge clock);
    check("restart_fs",    32'(fs2), 32'd1);
    check("restart_hsync", 32'(hs2), 32'd0);
    check("restart_vsync", 32'(vs2), 32'd1);
    check("restart_fc",    32'(fc2), 32'd1);

    check("queue_drained", 32'(q.size()), 32'd0);
    check("blank_zero",    32'(blank_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
